async_fifo: RTL and testbench

Parameterised first-in/first-out buffer with registered read data, full/empty status and one-cycle overflow/underflow error pulses. It sits between a producer and a consumer that run in the same clock domain. It absorbs bursts of up to `fd` words and flags any write attempted while full and any read attempted while empty.

---
 rtl/async_fifo.sv | 67 ++++++
 tb/tb_async_fifo.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/async_fifo.sv
// Single-clock FIFO with registered read data, pointer-decoded full/empty and
// one-cycle overflow/underflow pulses. r_clk exists only for pin compatibility.
module async_fifo #(
  parameter int unsigned fw       = 8,
  parameter int unsigned fd       = 8,
  parameter int unsigned add_size = 3
) (
  input  logic          w_clk,
  input  logic          r_clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          rd,
  input  logic [fw-1:0] wdata,
  output logic [fw-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned PW = add_size + 1;

  logic [fw-1:0] mem [fd];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          wr_ok_c;
  logic          rd_ok_c;
  logic          unused_r_clk;

  assign unused_r_clk = r_clk;

  // Status decode: extra wrap bit distinguishes full from empty.
  assign empty = (wptr == rptr);
  assign full  = (wptr[add_size-1:0] == rptr[add_size-1:0]) &&
                 (wptr[add_size] != rptr[add_size]);

  assign wr_ok_c = wr && !full;
  assign rd_ok_c = rd && !empty;

  // Storage is not reset; pointers make stale contents unreachable.
  always_ff @(posedge w_clk) begin
    if (wr_ok_c && !rst) begin
      mem[wptr[add_size-1:0]] <= wdata;
    end
  end

  always_ff @(posedge w_clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      rdata     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr && full;
      underflow <= rd && empty;
      if (wr_ok_c) begin
        wptr <= wptr + PW'(1);
      end
      if (rd_ok_c) begin
        rdata <= mem[rptr[add_size-1:0]];
        rptr  <= rptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench: a queue-based model predicts per-cycle outputs; a negedge
// monitor pops and compares them against the FIFO.
module tb_async_fifo;

  localparam int unsigned FW = 8;
  localparam int unsigned FD = 8;

  typedef struct packed {
    logic [FW-1:0] rdata;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          unf;
  } exp_t;

  logic          w_clk = 1'b0;
  logic          rst;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [FW-1:0] wdata = '0;
  logic [FW-1:0] rdata;
  logic          full, empty, overflow, underflow;

  int checks = 0;
  int passed = 0;

  logic [FW-1:0] mq [$];
  exp_t          expq [$];
  logic [FW-1:0] m_rdata;

  async_fifo #(.fw(FW), .fd(FD), .add_size(3)) dut (
    .w_clk(w_clk), .r_clk(w_clk), .rst(rst), .wr(wr), .rd(rd),
    .wdata(wdata), .rdata(rdata), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 w_clk = ~w_clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endfunction

  // Reference model: occupancy is just the size of a word queue.
  always @(posedge w_clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      expq.delete();
      m_rdata = '0;
    end else begin
      bit was_full, was_empty, m_ovf, m_unf;
      exp_t e;
      was_full  = (mq.size() == FD);
      was_empty = (mq.size() == 0);
      m_ovf = wr && was_full;
      m_unf = rd && was_empty;
      if (rd && !was_empty) m_rdata = mq.pop_front();
      if (wr && !was_full) mq.push_back(wdata);
      e.rdata = m_rdata;
      e.full  = (mq.size() == FD);
      e.empty = (mq.size() == 0);
      e.ovf   = m_ovf;
      e.unf   = m_unf;
      expq.push_back(e);
    end
  end

  always @(negedge w_clk) begin
    if (!rst && expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("rdata", 32'(rdata), 32'(e.rdata));
      chk("full", 32'(full), 32'(e.full));
      chk("empty", 32'(empty), 32'(e.empty));
      chk("overflow", 32'(overflow), 32'(e.ovf));
      chk("underflow", 32'(underflow), 32'(e.unf));
    end
  end

  task automatic drive(input logic w, input logic r, input logic [FW-1:0] d);
    wr = w; rd = r; wdata = d;
    @(posedge w_clk);
    #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_unf"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    #1;
    check_reset_state("rst_init");
    @(negedge w_clk);
    rst = 1'b0;
    @(posedge w_clk);
    #1;

    // Fill, overflow, drain, underflow
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, FW'(i));
    drive(1'b1, 1'b0, FW'(8));
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, '0);

    // Wrap with simultaneous access
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, FW'(8'h10 + i));
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, '0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, FW'(8'h20 + i));

    // Both requests on a full FIFO, then on an empty FIFO
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, FW'(8'h40 + i));
    drive(1'b1, 1'b1, 8'h55);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, '0);
    drive(1'b1, 1'b1, 8'h66);
    drive(1'b0, 1'b1, '0);

    // Reset pulsed between edges with 4 words stored
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, FW'(8'h70 + i));
    @(negedge w_clk);
    #1 rst = 1'b1;
    #1 check_reset_state("rst_mid");
    #1 rst = 1'b0;
    drive(1'b1, 1'b0, 8'hA5);
    drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, '0);
    #5 chk("a5_after_reset", 32'(rdata), 32'hA5);

    // Random traffic, write-biased then read-biased
    for (int i = 0; i < 300; i++) begin
      int unsigned pw;
      pw = (i < 150) ? 70 : 30;
      drive(logic'($urandom_range(99, 0) < pw),
            logic'($urandom_range(99, 0) < 100 - pw),
            FW'($urandom_range(255, 0)));
    end

    drive(1'b0, 1'b0, '0);
    @(negedge w_clk);
    #1;
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
